// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - periodic ultrasonic trigger/echo ranger reporting distance in mm
module ultrasonic_ranger #(
    parameter int CYC_PER_MM    = 157,
    parameter int TRIG_CYCLES   = 270,
    parameter int PERIOD_MS     = 60,
    parameter int ECHO_WAIT_CYC = 810000,
    parameter int MAX_MM        = 4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_1khz,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] dist_mm,
    output logic        dist_valid,
    output logic        err,
    output logic        busy
);

    localparam int PRE_W  = $clog2(CYC_PER_MM + 1);
    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int WAIT_W = $clog2(ECHO_WAIT_CYC + 1);
    localparam int TICK_W = $clog2(PERIOD_MS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic              echo_s1, echo_s2, echo_d;
    logic              clk_1khz_d;
    logic [TICK_W-1:0] tick_cnt;
    logic [TRIG_W-1:0] trig_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [PRE_W-1:0]  pre_cnt;
    logic [15:0]       mm_cnt;

    logic              tick, tick_last, echo_rise, err_next, count_en;
    logic [PRE_W-1:0]  pre_base;
    logic [15:0]       mm_base;

    assign tick      = clk_1khz & ~clk_1khz_d;
    assign tick_last = (tick_cnt == TICK_W'(PERIOD_MS - 1));
    assign echo_rise = echo_s2 & ~echo_d;

    always_comb begin
        next_state = state;
        err_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick && tick_last) next_state = S_TRIG;
            end
            S_TRIG: begin
                if (trig_cnt == TRIG_W'(TRIG_CYCLES - 1)) next_state = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                if (echo_rise) begin
                    next_state = S_MEASURE;
                end else if (wait_cnt == WAIT_W'(ECHO_WAIT_CYC - 1)) begin
                    next_state = S_IDLE;
                    err_next   = 1'b1;
                end
            end
            S_MEASURE: begin
                if (!echo_s2) begin
                    next_state = S_DONE;
                end else if (mm_cnt == 16'(MAX_MM)) begin
                    next_state = S_IDLE;
                    err_next   = 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // The rise cycle is itself the first echo-high cycle, so counting starts from 0/0 on it;
    // this makes dist_mm = floor(echo_high_cycles / CYC_PER_MM).
    always_comb begin
        count_en = ((state == S_WAIT_ECHO) && echo_rise) ||
                   ((state == S_MEASURE) && (next_state == S_MEASURE));
        pre_base = (state == S_MEASURE) ? pre_cnt : '0;
        mm_base  = (state == S_MEASURE) ? mm_cnt  : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            echo_s1    <= 1'b0;
            echo_s2    <= 1'b0;
            echo_d     <= 1'b0;
            clk_1khz_d <= 1'b0;
            tick_cnt   <= '0;
            trig_cnt   <= '0;
            wait_cnt   <= '0;
            pre_cnt    <= '0;
            mm_cnt     <= '0;
            trig       <= 1'b0;
            busy       <= 1'b0;
            dist_valid <= 1'b0;
            err        <= 1'b0;
            dist_mm    <= '0;
        end else begin
            state      <= next_state;
            echo_s1    <= echo;
            echo_s2    <= echo_s1;
            echo_d     <= echo_s2;
            clk_1khz_d <= clk_1khz;

            if ((state == S_IDLE) && tick) begin
                tick_cnt <= tick_last ? '0 : tick_cnt + TICK_W'(1);
            end

            trig_cnt <= ((state == S_TRIG) && (next_state == S_TRIG)) ?
                        trig_cnt + TRIG_W'(1) : '0;
            wait_cnt <= ((state == S_WAIT_ECHO) && (next_state == S_WAIT_ECHO)) ?
                        wait_cnt + WAIT_W'(1) : '0;

            // mm_cnt never passes MAX_MM: the FSM aborts on equality before another increment
            if (count_en) begin
                if (pre_base == PRE_W'(CYC_PER_MM - 1)) begin
                    pre_cnt <= '0;
                    mm_cnt  <= mm_base + 16'd1;
                end else begin
                    pre_cnt <= pre_base + PRE_W'(1);
                    mm_cnt  <= mm_base;
                end
            end else if (state != S_MEASURE) begin
                pre_cnt <= '0;
                mm_cnt  <= '0;
            end

            trig       <= (next_state == S_TRIG);
            busy       <= (next_state != S_IDLE);
            dist_valid <= (next_state == S_DONE);
            err        <= err_next;
            if (next_state == S_DONE) begin
                dist_mm <= mm_cnt;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - scoreboard bench for ultrasonic_ranger with scaled timing parameters
module tb_ultrasonic_ranger;

    localparam int CYC_PER_MM    = 20;
    localparam int TRIG_CYCLES   = 27;
    localparam int PERIOD_MS     = 3;
    localparam int ECHO_WAIT_CYC = 2500;
    localparam int MAX_MM        = 150;
    localparam int KHZ_HALF      = 20;
    localparam int FULL_SCALE    = MAX_MM * CYC_PER_MM;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_1khz = 1'b0;
    logic        echo = 1'b0;
    logic        trig;
    logic [15:0] dist_mm;
    logic        dist_valid;
    logic        err;
    logic        busy;

    ultrasonic_ranger #(
        .CYC_PER_MM   (CYC_PER_MM),
        .TRIG_CYCLES  (TRIG_CYCLES),
        .PERIOD_MS    (PERIOD_MS),
        .ECHO_WAIT_CYC(ECHO_WAIT_CYC),
        .MAX_MM       (MAX_MM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_1khz  (clk_1khz),
        .echo      (echo),
        .trig      (trig),
        .dist_mm   (dist_mm),
        .dist_valid(dist_valid),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            repeat (KHZ_HALF) @(posedge clk);
            #1 clk_1khz = ~clk_1khz;
        end
    end

    typedef struct {
        bit is_err;
        int cyc;
        int mm;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_dist  = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    task automatic expect_valid(input int at, input int h);
        model_dist = h / CYC_PER_MM;
        sb.push_back('{1'b0, at, model_dist});
    endtask

    task automatic expect_err(input int at);
        sb.push_back('{1'b1, at, model_dist});
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (dist_valid || err)) begin
            check("strobe_exclusive", int'(dist_valid && err), 0);
            if (sb.size() == 0) begin
                flag($sformatf("unexpected_strobe dist_valid=%0d err=%0d", dist_valid, err));
            end else begin
                e = sb.pop_front();
                check("strobe_kind_err", int'(err), int'(e.is_err));
                check("strobe_cycle", cyc, e.cyc);
                check("dist_mm", int'(dist_mm), e.mm);
            end
        end
    end

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            flag($sformatf("missing_strobe %0d expected strobe(s) never seen", sb.size()));
            sb.delete();
        end
    endtask

    task automatic wait_trig(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (trig) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) flag($sformatf("trig_timeout no trig within %0d cycles", budget));
    endtask

    task automatic trig_width(output int f);
        int n = 1;
        while (n < TRIG_CYCLES + 10) begin
            @(negedge clk);
            if (!trig) break;
            n++;
        end
        check("trig_width", n, TRIG_CYCLES);
        f = cyc;
    endtask

    // h == 0 means no echo at all (timeout)
    task automatic run_cycle(input bit have_trig, input int delay, input int h);
        int t, f, r, e;
        if (!have_trig) begin
            wait_trig(PERIOD_MS * 2 * KHZ_HALF * 2 + 50, t);
            if (t < 0) return;
        end
        trig_width(f);
        if (h == 0) begin
            expect_err(f + ECHO_WAIT_CYC);
            drain(ECHO_WAIT_CYC + 50);
            return;
        end
        repeat (delay) @(posedge clk);
        #1 echo = 1'b1;
        r = cyc;
        if (h > FULL_SCALE) expect_err(r + 3 + FULL_SCALE);
        repeat (h) @(posedge clk);
        #1 echo = 1'b0;
        e = cyc;
        if (h <= FULL_SCALE) expect_valid(e + 3, h);
        drain(60);
    endtask

    task automatic check_first_trig();
        int seen = 0;
        int k = 0;
        int t = -1;
        bit prev_k = clk_1khz;
        for (int i = 0; i < (PERIOD_MS + 2) * 2 * KHZ_HALF; i++) begin
            @(negedge clk);
            if (trig) begin
                t = cyc;
                break;
            end
            if (clk_1khz && !prev_k) begin
                seen++;
                if (seen == PERIOD_MS) k = cyc;
            end
            prev_k = clk_1khz;
        end
        check("first_trig_cycle", t, k + 1);
    endtask

    // Reset pulse timed into the low half of clk_1khz so the tick edge detector starts cleanly
    task automatic reset_pulse();
        @(negedge clk_1khz);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        echo = 1'b0;
        model_dist = 0;
        @(negedge clk);
        check("rst_trig_low", int'(trig), 0);
        check("rst_busy_low", int'(busy), 0);
        check("rst_dist_clear", int'(dist_mm), 0);
        check_first_trig();
    endtask

    initial begin
        int t, f, d, h;
        repeat (5) @(negedge clk);
        check("reset_trig", int'(trig), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_dist_valid", int'(dist_valid), 0);
        check("reset_err", int'(err), 0);
        check("reset_dist_mm", int'(dist_mm), 0);
        @(negedge clk_1khz);
        @(posedge clk);
        #1 rst = 1'b0;
        check_first_trig();

        run_cycle(1'b1, 0, 0);
        run_cycle(1'b0, 0, 0);
        run_cycle(1'b0, 1000, 100 * CYC_PER_MM);
        run_cycle(1'b0, 37, 101 * CYC_PER_MM - 1);
        run_cycle(1'b0, 5, 101 * CYC_PER_MM);
        run_cycle(1'b0, 200, FULL_SCALE + 1);
        run_cycle(1'b0, 3, FULL_SCALE);

        // echo already high when the trigger ends: no rise, so timeout
        wait_trig(400, t);
        echo = 1'b1;
        trig_width(f);
        expect_err(f + ECHO_WAIT_CYC);
        drain(ECHO_WAIT_CYC + 50);
        echo = 1'b0;

        wait_trig(400, t);
        reset_pulse();
        run_cycle(1'b1, 50, 777);

        wait_trig(400, t);
        trig_width(f);
        repeat (5) @(posedge clk);
        #1 echo = 1'b1;
        repeat (100) @(posedge clk);
        reset_pulse();
        run_cycle(1'b1, 10, 1234);

        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(1, 1500));
            h = int'($urandom_range(1, FULL_SCALE + 40));
            if ($urandom_range(0, 7) == 0) h = 0;
            run_cycle(1'b0, d, h);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ultrasonic_ranger.md
ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 Parameter CYC_PER_MM, default 157, clk cycles of echo high per 1 mm of target distance (27 MHz, 343 m/s, round trip).
REQ-002 Parameter TRIG_CYCLES, default 270, trigger pulse width in clk cycles (10 us).
REQ-003 Parameter PERIOD_MS, default 60, measurement repetition period in 1 kHz ticks.
REQ-004 Parameter ECHO_WAIT_CYC, default 810000, max clk cycles from trigger fall to echo rise (30 ms).
REQ-005 Parameter MAX_MM, default 4000, distance at which an ongoing echo is aborted as out-of-range.
REQ-006 clk  input  1  27 MHz system clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 clk_1khz  input  1  1 kHz square wave from the clock divider, synchronous to clk.
REQ-009 echo  input  1  asynchronous echo line from sensor, active high.
REQ-010 trig  output  1  trigger to sensor, active high.
REQ-011 dist_mm  output  16  last valid distance in mm.
REQ-012 dist_valid  output  1  one-cycle strobe when dist_mm updates.
REQ-013 err  output  1  one-cycle strobe on timeout or out-of-range.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 echo SHALL pass through a 2-flop synchronizer; all echo decisions use the synchronized value.
REQ-016 A tick SHALL be the clk cycle where clk_1khz is 1 and its registered previous value is 0 (rising-edge detect); level of clk_1khz is never used directly.
REQ-017 States: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
REQ-018 IDLE: count ticks; on the PERIOD_MS-th tick go to TRIG and clear tick count; ticks outside IDLE are ignored.
REQ-019 TRIG: trig high for exactly TRIG_CYCLES consecutive cycles, then WAIT_ECHO with trig low.
REQ-020 WAIT_ECHO: on synchronized echo rise go to MEASURE with mm counter and prescaler at 0; if ECHO_WAIT_CYC cycles elapse first, pulse err and go to IDLE.
REQ-021 Echo already high on entry to WAIT_ECHO SHALL not count as a rise; a 0->1 transition is required.
REQ-022 MEASURE: prescaler counts 0..CYC_PER_MM-1 while echo high, wrapping to 0 and incrementing mm counter on wrap.
REQ-023 MEASURE: on echo fall go to DONE; if mm counter reaches MAX_MM while echo high, pulse err and go to IDLE without updating dist_mm.
REQ-024 DONE (one cycle): dist_mm <= mm counter (partial prescaler count truncated), dist_valid = 1, next state IDLE.
REQ-025 dist_valid and err SHALL never assert in the same cycle and each is exactly one cycle wide.
REQ-026 mm counter 16 bits, prescaler and wait counter sized to their parameter maxima; no counter wraps silently.
REQ-027 dist_mm holds its value between updates, including across err events.
REQ-028 Latency: dist_valid asserts 3 clk cycles after raw echo fall (2 sync + DONE register).

Reset
REQ-029 While rst high: state IDLE, all counters 0, trig 0, dist_mm 0, dist_valid 0, err 0, busy 0, synchronizer and edge-detect flops 0.
REQ-030 rst asserted in any state, including mid-trigger or mid-measure, SHALL abort immediately; trig low on the cycle after rst sampled high; no strobe emitted.
REQ-031 After rst release the first trig SHALL occur on the PERIOD_MS-th tick edge.

Verification
REQ-032 Release rst, toggle clk_1khz at 1 kHz, echo low -> trig high for 270 cycles after 60th tick; err after 810000 further cycles; cycle repeats.
REQ-033 Echo rises 1000 cycles after trig fall, high 15700 cycles -> dist_mm = 100, dist_valid one cycle, 3 cycles after echo fall.
REQ-034 Echo high 15856 cycles -> dist_mm = 100 (truncation); 15857 cycles -> 101.
REQ-035 Echo held high > 4000*157 cycles -> err strobe, dist_mm keeps previous 100, return to IDLE.
REQ-036 Assert rst for 1 cycle during TRIG and again during MEASURE -> trig drops, no dist_valid/err, next trig on 60th tick after release.
REQ-037 Echo high before trig falls and stays high -> no measurement start, err after ECHO_WAIT_CYC.
